// File: rtl/xvga_timing_pkg.sv
// Shared 1024x768@60 raster constants, counter widths and window-decode helper.
package xvga_timing_pkg;

  localparam int unsigned XGA_H_ACTIVE = 1024;
  localparam int unsigned XGA_H_FP     = 24;
  localparam int unsigned XGA_H_SYNC   = 136;
  localparam int unsigned XGA_H_BP     = 160;
  localparam int unsigned XGA_H_TOTAL  = XGA_H_ACTIVE + XGA_H_FP + XGA_H_SYNC + XGA_H_BP;

  localparam int unsigned XGA_V_ACTIVE = 768;
  localparam int unsigned XGA_V_FP     = 3;
  localparam int unsigned XGA_V_SYNC   = 6;
  localparam int unsigned XGA_V_BP     = 29;
  localparam int unsigned XGA_V_TOTAL  = XGA_V_ACTIVE + XGA_V_FP + XGA_V_SYNC + XGA_V_BP;

  // Matches the registered latency of the downstream sprite stages.
  localparam int unsigned XGA_PIPE_DELAY = 3;

  localparam int unsigned COUNT_W_H = 11;
  localparam int unsigned COUNT_W_V = 10;

  function automatic logic in_window(input int unsigned val, input int unsigned lo,
                                     input int unsigned len);
    return (val >= lo) && (val < lo + len);
  endfunction

endpackage

// File: rtl/xvga_timing_sync_delay_line.sv
// Fixed-depth shift register that realigns sync/blank with pipelined pixel data.
module xvga_timing_sync_delay_line #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             pixel_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/xvga_timing.sv
// Raster counter and sync/blank decode for the pixel pipeline, plus delayed syncs.
module xvga_timing
  import xvga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = XGA_H_ACTIVE,
  parameter int unsigned H_FP       = XGA_H_FP,
  parameter int unsigned H_SYNC     = XGA_H_SYNC,
  parameter int unsigned H_BP       = XGA_H_BP,
  parameter int unsigned V_ACTIVE   = XGA_V_ACTIVE,
  parameter int unsigned V_FP       = XGA_V_FP,
  parameter int unsigned V_SYNC     = XGA_V_SYNC,
  parameter int unsigned V_BP       = XGA_V_BP,
  parameter bit          HSYNC_POL  = 1'b0,
  parameter bit          VSYNC_POL  = 1'b0,
  parameter int unsigned PIPE_DELAY = XGA_PIPE_DELAY
) (
  input  logic                 pixel_clk,
  input  logic                 reset,
  output logic [COUNT_W_H-1:0] hcount,
  output logic [COUNT_W_V-1:0] vcount,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 blank,
  output logic                 hsync_d,
  output logic                 vsync_d,
  output logic                 blank_d,
  output logic                 line_start,
  output logic                 frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [COUNT_W_H-1:0] H_LAST = COUNT_W_H'(H_TOTAL - 1);
  localparam logic [COUNT_W_V-1:0] V_LAST = COUNT_W_V'(V_TOTAL - 1);

  if (H_TOTAL > 2048 || V_TOTAL > 1024 || PIPE_DELAY < 1 || PIPE_DELAY > 15) begin : g_bad_cfg
    $error("xvga_timing: totals exceed counter range or PIPE_DELAY outside 1..15");
  end

  logic [COUNT_W_H-1:0] h_next;
  logic [COUNT_W_V-1:0] v_next;
  logic                 hsync_next;
  logic                 vsync_next;
  logic                 blank_next;
  logic [2:0]           sync_d;

  // Decode from the next counter values so registered flags line up with hcount/vcount.
  always_comb begin
    h_next = hcount + COUNT_W_H'(1);
    v_next = vcount;
    if (hcount == H_LAST) begin
      h_next = '0;
      v_next = (vcount == V_LAST) ? '0 : vcount + COUNT_W_V'(1);
    end
    hsync_next = in_window(32'(h_next), H_ACTIVE + H_FP, H_SYNC) ? HSYNC_POL : ~HSYNC_POL;
    vsync_next = in_window(32'(v_next), V_ACTIVE + V_FP, V_SYNC) ? VSYNC_POL : ~VSYNC_POL;
    blank_next = (32'(h_next) >= H_ACTIVE) || (32'(v_next) >= V_ACTIVE);
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      blank       <= 1'b0;
      line_start  <= 1'b1;
      frame_start <= 1'b1;
    end else begin
      hcount      <= h_next;
      vcount      <= v_next;
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      blank       <= blank_next;
      line_start  <= (h_next == '0);
      frame_start <= (h_next == '0) && (v_next == '0);
    end
  end

  xvga_timing_sync_delay_line #(
    .WIDTH  (3),
    .DEPTH  (PIPE_DELAY),
    .RST_VAL({~HSYNC_POL, ~VSYNC_POL, 1'b1})
  ) u_sync_delay_line (
    .pixel_clk(pixel_clk),
    .reset    (reset),
    .din      ({hsync, vsync, blank}),
    .dout     (sync_d)
  );

  assign {hsync_d, vsync_d, blank_d} = sync_d;

endmodule

// File: tb/tb_xvga_timing.sv
// Checks a full-size and a reduced-geometry inverted-polarity instance against a cycle-index model.
module tb_xvga_timing;

  typedef struct {
    int ha, hf, hw, hb, va, vf, vw, vb, d;
    bit hp, vp;
  } geo_t;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic hs, vs, bl, ls, fs, hs_d, vs_d, bl_d;
  } exp_t;

  logic clk;
  logic rst;

  logic [10:0] hc0, hc1;
  logic [9:0]  vc0, vc1;
  logic hs0, vs0, bl0, hsd0, vsd0, bld0, ls0, fs0;
  logic hs1, vs1, bl1, hsd1, vsd1, bld1, ls1, fs1;

  int n_checks = 0;
  int n_errors = 0;
  int t_cnt    = 0;
  int hs_low_n = 0, ls_n = 0, unbl_n = 0, fs_n = 0, vs_n = 0;
  geo_t g_def, g_sml;

  xvga_timing dut (
    .pixel_clk(clk), .reset(rst), .hcount(hc0), .vcount(vc0),
    .hsync(hs0), .vsync(vs0), .blank(bl0),
    .hsync_d(hsd0), .vsync_d(vsd0), .blank_d(bld0),
    .line_start(ls0), .frame_start(fs0)
  );

  xvga_timing #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIPE_DELAY(5)
  ) dut_sml (
    .pixel_clk(clk), .reset(rst), .hcount(hc1), .vcount(vc1),
    .hsync(hs1), .vsync(vs1), .blank(bl1),
    .hsync_d(hsd1), .vsync_d(vsd1), .blank_d(bld1),
    .line_start(ls1), .frame_start(fs1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t_cnt, got, exp);
    end
  endtask

  // {hsync, vsync, blank} at cycle t after reset release, from the raster rules.
  function automatic logic [2:0] raw(input int t, input geo_t g);
    int ht, vt, h, v;
    logic hs_a, vs_a;
    ht = g.ha + g.hf + g.hw + g.hb;
    vt = g.va + g.vf + g.vw + g.vb;
    h = t % ht;
    v = (t / ht) % vt;
    hs_a = (h >= g.ha + g.hf) && (h < g.ha + g.hf + g.hw);
    vs_a = (v >= g.va + g.vf) && (v < g.va + g.vf + g.vw);
    return {hs_a ? g.hp : !g.hp, vs_a ? g.vp : !g.vp, (h >= g.ha) || (v >= g.va)};
  endfunction

  function automatic exp_t model(input int t, input geo_t g);
    exp_t e;
    int ht, vt, h, v;
    ht = g.ha + g.hf + g.hw + g.hb;
    vt = g.va + g.vf + g.vw + g.vb;
    h = t % ht;
    v = (t / ht) % vt;
    e.h = 11'(h);
    e.v = 10'(v);
    {e.hs, e.vs, e.bl} = raw(t, g);
    e.ls = (h == 0);
    e.fs = (h == 0) && (v == 0);
    if (t >= g.d) {e.hs_d, e.vs_d, e.bl_d} = raw(t - g.d, g);
    else          {e.hs_d, e.vs_d, e.bl_d} = {!g.hp, !g.vp, 1'b1};
    return e;
  endfunction

  task automatic cmp_dut(input string p, input exp_t e, input logic [10:0] h, input logic [9:0] v,
                         input logic hs, input logic vs, input logic bl, input logic ls,
                         input logic fs, input logic hsd, input logic vsd, input logic bld);
    chk_eq({p, ".hcount"},      32'(h),   32'(e.h));
    chk_eq({p, ".vcount"},      32'(v),   32'(e.v));
    chk_eq({p, ".hsync"},       32'(hs),  32'(e.hs));
    chk_eq({p, ".vsync"},       32'(vs),  32'(e.vs));
    chk_eq({p, ".blank"},       32'(bl),  32'(e.bl));
    chk_eq({p, ".line_start"},  32'(ls),  32'(e.ls));
    chk_eq({p, ".frame_start"}, 32'(fs),  32'(e.fs));
    chk_eq({p, ".hsync_d"},     32'(hsd), 32'(e.hs_d));
    chk_eq({p, ".vsync_d"},     32'(vsd), 32'(e.vs_d));
    chk_eq({p, ".blank_d"},     32'(bld), 32'(e.bl_d));
  endtask

  task automatic check_all();
    cmp_dut("def", model(t_cnt, g_def), hc0, vc0, hs0, vs0, bl0, ls0, fs0, hsd0, vsd0, bld0);
    cmp_dut("sml", model(t_cnt, g_sml), hc1, vc1, hs1, vs1, bl1, ls1, fs1, hsd1, vsd1, bld1);
  endtask

  // Per-line / per-frame totals observed from the first uninterrupted run.
  task automatic acc();
    if (t_cnt < 1344) begin
      if (hs0 == 1'b0) hs_low_n++;
      if (ls0) ls_n++;
    end
    if (t_cnt < 350) begin
      if (!bl1) unbl_n++;
      if (fs1) fs_n++;
      if (vs1) vs_n++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) t_cnt++;
    @(negedge clk);
    check_all();
  endtask

  // Assert reset between edges, confirm it clears before the next edge, release on a negedge.
  task automatic async_reset(input int hold);
    #($urandom_range(1, 3));
    rst = 1'b1;
    #1;
    t_cnt = 0;
    check_all();
    repeat (hold) tick();
    rst = 1'b0;
  endtask

  initial begin
    g_def = '{1024, 24, 136, 160, 768, 3, 6, 29, 3, 1'b0, 1'b0};
    g_sml = '{16, 2, 3, 4, 8, 1, 2, 3, 5, 1'b1, 1'b1};
    rst = 1'b1;
    repeat (3) tick();
    acc();
    rst = 1'b0;

    repeat (2700) begin
      tick();
      acc();
    end
    chk_eq("def.hsync_active_per_line", 32'(hs_low_n), 32'd136);
    chk_eq("def.line_start_per_line",   32'(ls_n),     32'd1);
    chk_eq("sml.unblanked_per_frame",   32'(unbl_n),   32'd128);
    chk_eq("sml.frame_start_per_frame", 32'(fs_n),     32'd1);
    chk_eq("sml.vsync_active_per_frame", 32'(vs_n),    32'd50);

    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(20, 2500)) tick();
      async_reset(int'($urandom_range(1, 3)));
    end

    while (t_cnt < 1344 || (t_cnt % 1344) != 500) tick();
    async_reset(2);
    repeat (400) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
